uart_tx: RTL and testbench
==========================

# uart_tx

Serial UART transmitter for the mini_spart datapath: takes a byte from the bus side and shifts it out on TX as an 8N1 frame, LSB first. The frame is one start bit (0), eight data bits and one stop bit (1). A one-entry holding buffer allows back-to-back frames with no idle gap between stop bit and next start bit. Its bit period and frame format match the design's UART receiver, so TX can drive that receiver's RX directly.

## Interface
- BAUD_DIV, 43: clock cycles per bit period; legal range 2..(2^BAUD_W − 1).
- BAUD_W, 6: width of the baud counter.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  reset, asynchronous, active-low.
- trmt  in  1  single-cycle request to transmit tx_data.
- tx_data  in  8  byte to send; sampled only in a cycle where trmt is accepted.
- clr_done  in  1  clears tx_done.
- TX  out  1  serial line; registered; idle level 1.
- busy  out  1  frame in progress (start bit through stop bit).
- buf_full  out  1  holding buffer occupied; trmt is ignored while high.
- tx_done  out  1  sticky frame-complete flag.

## Operation
- Reset values: TX=1, busy=0, buf_full=0, tx_done=0, state IDLE, all counters 0. Reset asserted mid-frame aborts the frame: TX returns to 1 asynchronously and any buffered byte is discarded.
- Datapath:
  - 10-bit shift register loaded with {1'b1, tx_data, 1'b0}; TX is driven from its bit 0.
  - baud_cnt counts 0..BAUD_DIV−1, then wraps to 0.
  - bit_cnt counts 0..9.
  - 8-bit holding buffer with a valid flag (buf_full).
- Shift event: baud_cnt == BAUD_DIV−1 in XMIT. On it, shift right (fill with 1), bit_cnt += 1, baud_cnt ← 0.
- States:
  - IDLE: baud_cnt and bit_cnt held at 0; busy=0. On trmt, load the shifter directly from tx_data (the buffer is bypassed) and go to XMIT.
  - XMIT: busy=1. On trmt with buf_full=0, capture tx_data into the buffer; buf_full=1 next cycle.
  - End of frame is the shift event with bit_cnt == 9:
    - If buf_full=1: load the shifter from the buffer, clear buf_full, zero bit_cnt, stay in XMIT.
    - Otherwise go to IDLE.
    - In both cases set tx_done.
- trmt while buf_full=1 is ignored, including in the cycle the buffer drains. The byte is lost and no state changes.
- tx_done is cleared by clr_done or by any accepted trmt in IDLE. If a set and a clear occur in the same cycle, the set wins.
- tx_data must be held stable only during the accepting cycle.

## Timing
- trmt accepted in IDLE at cycle 0:
  - TX=0 (start bit) from cycle 1.
  - Each bit holds exactly BAUD_DIV cycles.
  - Data bit k occupies cycles 1+(k+1)·BAUD_DIV .. (k+2)·BAUD_DIV.
  - Stop bit occupies cycles 1+9·BAUD_DIV .. 10·BAUD_DIV.
- Frame-end edge is at the end of cycle 10·BAUD_DIV. In cycle 10·BAUD_DIV+1:
  - tx_done=1.
  - busy=0 if the buffer was empty; otherwise busy stays 1 and the next start bit begins that cycle.
- Total frame length: 10·BAUD_DIV cycles. Back-to-back frames introduce zero extra cycles.
- busy rises in cycle 1 after an accepted trmt; buf_full rises the cycle after buffered acceptance.
- Latency trmt→TX low: 1 cycle from IDLE.

## Test plan
- Reset → TX=1, busy=0, buf_full=0, tx_done=0. Deassert reset, idle 100 cycles → TX stays 1.
- trmt with 0xA5, BAUD_DIV=43:
  - TX reads 0,1,0,1,0,0,1,0,1,1 when sampled at the mid-point of each 43-cycle bit.
  - tx_done=1 and busy=0 at cycle 431.
- 0x00 sent, then 0xFF issued at cycle 50 (buffered, buf_full=1 from cycle 51):
  - Stop bit of 0x00 is followed immediately, at cycle 431, by the start bit of 0xFF.
  - buf_full drops at cycle 431; busy stays high until cycle 861.
- Overflow: 0x11 starts, 0x22 is buffered, then trmt with 0x33 while buf_full=1 → only 0x11 and 0x22 appear on TX; 0x33 is never sent.
- tx_done handling:
  - clr_done pulse after a frame → tx_done=0 next cycle.
  - clr_done in the same cycle as a frame end → tx_done=1.
- Reset mid-frame at bit 4 of 0x5A, with a byte buffered → TX=1 immediately; busy=0 and buf_full=0. A new trmt after release sends a clean full frame.

Source files
------------

// File: rtl/uart_tx.sv
// Purpose: 8N1 UART transmitter (LSB first) with a one-byte holding buffer for gapless back-to-back frames.
// Latency: TX drops to the start bit 1 cycle after trmt is accepted in IDLE; each bit lasts BAUD_DIV cycles.
// Backpressure: buf_full high means trmt is ignored and the offered byte is dropped; no stall is asserted upstream.
module uart_tx #(
   parameter int BAUD_DIV = 43,
   parameter int BAUD_W   = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       trmt,
   input  logic [7:0] tx_data,
   input  logic       clr_done,
   output logic       TX,
   output logic       busy,
   output logic       buf_full,
   output logic       tx_done
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XMIT = 1'b1;

   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);

   logic [0:0]        state;
   logic [9:0]        shift_reg;
   logic [BAUD_W-1:0] baud_cnt;
   logic [3:0]        bit_cnt;
   logic [7:0]        buf_dat;

   logic shift_evt;
   logic frame_end;
   logic accept_idle;
   logic accept_xmit;
   logic load_direct;

   assign shift_evt   = (state == XMIT) && (baud_cnt == BAUD_LAST);
   assign frame_end   = shift_evt && (bit_cnt == 4'd9);
   assign accept_idle = (state == IDLE) && trmt;
   assign accept_xmit = (state == XMIT) && trmt && !buf_full;
   // A byte offered exactly on the frame-end edge with an empty buffer would
   // otherwise be stranded in the buffer while the FSM drops to IDLE, so it is
   // loaded straight into the shifter and transmission continues gaplessly.
   assign load_direct = accept_xmit && frame_end;

   // The shifter's LSB is the registered serial line; reset value is all ones.
   assign TX   = shift_reg[0];
   assign busy = (state == XMIT);

   // FSM, baud timing, bit counting and the output shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         shift_reg <= '1;
         baud_cnt  <= '0;
         bit_cnt   <= '0;
      end else if (state == IDLE) begin
         baud_cnt <= '0;
         bit_cnt  <= '0;
         if (trmt) begin
            shift_reg <= {1'b1, tx_data, 1'b0};
            state     <= XMIT;
         end
      end else begin
         if (shift_evt) begin
            baud_cnt <= '0;
            if (frame_end) begin
               bit_cnt <= '0;
               if (buf_full) begin
                  shift_reg <= {1'b1, buf_dat, 1'b0};
               end else if (load_direct) begin
                  shift_reg <= {1'b1, tx_data, 1'b0};
               end else begin
                  shift_reg <= {1'b1, shift_reg[9:1]};
                  state     <= IDLE;
               end
            end else begin
               bit_cnt   <= bit_cnt + 4'd1;
               shift_reg <= {1'b1, shift_reg[9:1]};
            end
         end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
         end
      end
   end

   // Holding buffer: filled by a byte accepted mid-frame, drained at frame end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         buf_full <= 1'b0;
         buf_dat  <= '0;
      end else if (frame_end && buf_full) begin
         buf_full <= 1'b0;
      end else if (accept_xmit && !frame_end) begin
         buf_dat  <= tx_data;
         buf_full <= 1'b1;
      end
   end

   // Sticky completion flag; a frame end in the same cycle as a clear wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_done <= 1'b0;
      end else if (frame_end) begin
         tx_done <= 1'b1;
      end else if (clr_done || accept_idle) begin
         tx_done <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a frame-schedule reference model predicts every output each
// cycle, and a line-level receiver pops expected bytes from a scoreboard queue.
module tb_uart_tx;

   localparam int D = 43;

   logic       clk      = 1'b0;
   logic       rst_n    = 1'b0;
   logic       trmt     = 1'b0;
   logic       clr_done = 1'b0;
   logic [7:0] tx_data  = 8'h00;
   logic       TX;
   logic       busy;
   logic       buf_full;
   logic       tx_done;

   uart_tx #(.BAUD_DIV(D), .BAUD_W(6)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .trmt     (trmt),
      .tx_data  (tx_data),
      .clr_done (clr_done),
      .TX       (TX),
      .busy     (busy),
      .buf_full (buf_full),
      .tx_done  (tx_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // A frame is described only by when it was accepted, when its start bit
   // begins and its last (stop-bit) cycle, plus its payload.
   typedef struct {
      int         acc;
      int         st;
      int         en;
      logic [7:0] d;
   } frame_t;

   frame_t     frames[$];
   logic [7:0] sbq[$];
   logic       m_done = 1'b0;
   int         n_chk  = 0;
   int         n_fail = 0;

   logic       rx_act  = 1'b0;
   int         rx_cnt  = 0;
   logic [9:0] rx_bits = '0;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic check_cycle();
      logic   e_tx, e_busy, e_bf, set_done, acc;
      int     pend, k, c;
      frame_t nf;
      c = cyc;
      if (!rst_n) begin
         frames.delete();
         sbq.delete();
         rx_act = 1'b0;
         m_done = 1'b0;
         chk("reset_tx", TX, 1);
         chk("reset_busy", busy, 0);
         chk("reset_buf_full", buf_full, 0);
         chk("reset_tx_done", tx_done, 0);
         return;
      end
      // Expected outputs this cycle, from the frame schedule.
      e_tx = 1'b1; e_busy = 1'b0; e_bf = 1'b0;
      foreach (frames[i]) begin
         if (frames[i].st <= c && c <= frames[i].en) begin
            e_busy = 1'b1;
            k = (c - frames[i].st) / D;
            if (k == 0) e_tx = 1'b0;
            else if (k < 9) e_tx = frames[i].d[k-1];
         end
         if (frames[i].acc < c && frames[i].st > c) e_bf = 1'b1;
      end
      chk("tx_line", TX, e_tx);
      chk("busy", busy, e_busy);
      chk("buf_full", buf_full, e_bf);
      chk("tx_done", tx_done, m_done);

      // Receiver: find the start edge, sample mid-bit, compare with scoreboard.
      if (!rx_act && TX == 1'b0) begin
         rx_act = 1'b1;
         rx_cnt = 0;
      end
      if (rx_act) begin
         if (rx_cnt % D == D / 2) rx_bits[rx_cnt / D] = TX;
         if (rx_cnt == 9 * D + D / 2) begin
            chk("rx_start_bit", rx_bits[0], 0);
            chk("rx_stop_bit", rx_bits[9], 1);
            chk("rx_frame_expected", sbq.size() != 0, 1);
            if (sbq.size() != 0) chk("rx_byte", rx_bits[8:1], sbq.pop_front());
            rx_act = 1'b0;
         end else begin
            rx_cnt++;
         end
      end

      // Apply this cycle's inputs to the model.
      set_done = 1'b0; pend = 0; acc = 1'b0;
      foreach (frames[i]) begin
         if (frames[i].en == c) set_done = 1'b1;
         if (frames[i].en >= c) pend++;
      end
      if (trmt && pend < 2) begin
         nf.acc = c;
         nf.d   = tx_data;
         nf.st  = (pend == 0) ? c + 1 : frames[$].en + 1;
         nf.en  = nf.st + 10 * D - 1;
         frames.push_back(nf);
         sbq.push_back(tx_data);
         acc = (pend == 0);
      end
      if (set_done) m_done = 1'b1;
      else if (clr_done || acc) m_done = 1'b0;
      while (frames.size() > 0 && frames[0].en < c) void'(frames.pop_front());
   endtask

   initial forever begin
      @(negedge clk);
      check_cycle();
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [7:0] d);
      trmt    = 1'b1;
      tx_data = d;
      tick(1);
      trmt    = 1'b0;
      tx_data = 8'($urandom);
   endtask

   initial begin
      #4_000_000;
      $display("FAIL watchdog: simulation exceeded its time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      rst_n = 1'b1;
      tick(100);
      // Single frame.
      send(8'hA5);
      tick(440);
      // Back-to-back through the buffer.
      send(8'h00);
      tick(49);
      send(8'hFF);
      tick(900);
      // Overflow: third byte offered while the buffer is occupied.
      send(8'h11);
      tick(5);
      send(8'h22);
      tick(5);
      send(8'h33);
      tick(900);
      // Clear after a completed frame.
      send(8'hC3);
      tick(440);
      clr_done = 1'b1;
      tick(1);
      clr_done = 1'b0;
      tick(5);
      // Clear in the very cycle of the frame-end edge.
      send(8'h96);
      tick(10 * D - 1);
      clr_done = 1'b1;
      tick(1);
      clr_done = 1'b0;
      tick(20);
      // Reset during data bit 4 with a byte buffered.
      send(8'h5A);
      tick(10);
      send(8'hE7);
      tick(5 * D + 10);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async_reset_tx", TX, 1);
      chk("async_reset_busy", busy, 0);
      chk("async_reset_buf_full", buf_full, 0);
      tick(2);
      rst_n = 1'b1;
      tick(5);
      send(8'h3C);
      tick(440);
      // Random traffic and clears.
      repeat (15000) begin
         trmt     = ($urandom_range(0, 149) == 0);
         tx_data  = 8'($urandom);
         clr_done = ($urandom_range(0, 99) == 0);
         tick(1);
      end
      trmt     = 1'b0;
      clr_done = 1'b0;
      tick(900);
      chk("scoreboard_drained", sbq.size() == 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
